// File: rtl/lmac_reg_rd_responder.sv
// LMAC-side register-read responder: edge-detects a host read request, decodes the address
// against the ID/counter/status map and answers with registered data and a one-cycle done pulse.
module lmac_reg_rd_responder #(
  parameter logic [31:0] ID_VALUE    = 32'h4C4D_0003,
  parameter int          NUM_STAT    = 8,
  parameter logic [31:0] BAD_DATA    = 32'hDEAD_BEEF,
  parameter bit          CLR_ON_READ = 1'b0
) (
  input  logic                  fmac_clk,
  input  logic                  reset,
  input  logic [15:0]           host_addr,
  input  logic                  reg_rd_start,
  input  logic [NUM_STAT*32-1:0] stat_in,
  output logic [31:0]           mac_regdout,
  output logic                  reg_rd_done,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    RESPOND
  } state_t;

  state_t      state_q, state_d;
  logic        start_d;
  logic        start_edge;
  logic [15:0] addr_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_count, bad_addr_count, overrun_count;

  logic [13:0] word;
  logic        mapped;
  logic [31:0] sel_data;
  logic        sel_rd, sel_bad, sel_ovr;
  logic        in_decode, in_respond;
  logic        clr_rd, clr_bad, clr_ovr;
  logic        inc_bad, inc_ovr;

  assign start_edge = reg_rd_start & ~start_d;
  assign busy       = (state_q != IDLE);
  assign in_decode  = (state_q == DECODE);
  assign in_respond = (state_q == RESPOND);

  // Counters saturate; a clear wins over the old value but a coincident increment still lands.
  function automatic logic [31:0] ctr_next(input logic [31:0] v, input logic inc, input logic clr);
    if (clr)                      return {31'd0, inc};
    if (inc && v != 32'hFFFF_FFFF) return v + 32'd1;
    return v;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_edge) state_d = DECODE;
      DECODE:  state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_data = BAD_DATA;
    mapped   = 1'b0;
    sel_rd   = 1'b0;
    sel_bad  = 1'b0;
    sel_ovr  = 1'b0;
    word     = addr_q[15:2];
    if (addr_q[1:0] == 2'b00) begin
      case (word)
        14'd0: begin sel_data = ID_VALUE;       mapped = 1'b1;                 end
        14'd1: begin sel_data = rd_count;       mapped = 1'b1; sel_rd  = 1'b1; end
        14'd2: begin sel_data = bad_addr_count; mapped = 1'b1; sel_bad = 1'b1; end
        14'd3: begin sel_data = overrun_count;  mapped = 1'b1; sel_ovr = 1'b1; end
        default: begin
          for (int i = 0; i < NUM_STAT; i++) begin
            if (word == 14'(i + 4)) begin
              sel_data = stat_in[32*i +: 32];
              mapped   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign clr_rd  = CLR_ON_READ & in_decode & sel_rd;
  assign clr_bad = CLR_ON_READ & in_decode & sel_bad;
  assign clr_ovr = CLR_ON_READ & in_decode & sel_ovr;
  assign inc_bad = in_decode & ~mapped;
  assign inc_ovr = start_edge & (state_q != IDLE);

  always_ff @(posedge fmac_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      start_d        <= 1'b0;
      addr_q         <= '0;
      rdata_q        <= '0;
      mac_regdout    <= '0;
      reg_rd_done    <= 1'b0;
      rd_count       <= '0;
      bad_addr_count <= '0;
      overrun_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
      state_q     <= state_d;
      start_d     <= reg_rd_start;
      reg_rd_done <= in_respond;
      if (state_q == IDLE && start_edge) addr_q <= host_addr;
      if (in_decode)                     rdata_q <= sel_data;
      if (in_respond)                    mac_regdout <= rdata_q;
      rd_count       <= ctr_next(rd_count,       in_respond, clr_rd);
      bad_addr_count <= ctr_next(bad_addr_count, inc_bad,    clr_bad);
      overrun_count  <= ctr_next(overrun_count,  inc_ovr,    clr_ovr);
    end
  end

endmodule
